rw_capture_fifo: RTL
====================

# rw_capture_fifo

Downstream consumer of the read/write/ready strobe stage. Write data is staged on `write` and committed to a DEPTH-entry FIFO on the following `ready`. `read` pops the oldest entry with a registered, one-cycle response. Sticky error flags record protocol violations (overflow, underflow, stray ready, read and write together) for the property checkers bound alongside it.

## Interface
Parameters:
- `WIDTH`, 8: data width.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `read`  in  1  pop request from upstream stage.
- `write`  in  1  write request; `wdata` valid this cycle.
- `ready`  in  1  commit strobe for the staged write.
- `wdata`  in  WIDTH  write data.
- `rdata`  out  WIDTH  popped data, valid when `rvalid`.
- `rvalid`  out  1  one-cycle pulse, pop response.
- `count`  out  $clog2(DEPTH+1)  committed entries.
- `full`  out  1  `count == DEPTH`, combinational from `count`.
- `empty`  out  1  `count == 0`, combinational from `count`.
- `overflow`  out  1  sticky: commit attempted while full.
- `underflow`  out  1  sticky: read while empty.
- `stray_ready`  out  1  sticky: `ready` with nothing staged.
- `rw_conflict`  out  1  sticky: `read && write` in the same cycle.

## Operation
- Staging register: `stage_valid`, `stage_data`. `write` (no conflict) loads `stage_data <= wdata` and sets `stage_valid <= 1`.
- Commit on `ready && stage_valid`:
  - If not full, push `stage_data` at the write pointer and clear `stage_valid` (unless a new write reloads it the same cycle).
  - If full, drop the entry, set `overflow`, and clear `stage_valid`.
- `ready && !stage_valid` sets `stray_ready`; no other effect.
- A second `write` while `stage_valid` and no `ready` overwrites `stage_data`. The earlier staged value is lost; no flag is raised.
- Same cycle `write` and `ready` with `stage_valid`: commit the old `stage_data` first, then load the new `wdata`; `stage_valid` stays 1.
- `read` (no conflict):
  - If not empty: `rdata <= mem[rd_ptr]`, `rvalid <= 1`, `rd_ptr++`.
  - If empty: `underflow <= 1`, `rvalid <= 0`.
  - Empty is judged on pre-edge `count`, so a same-cycle commit does not satisfy the read.
- `read && write`: set `rw_conflict`. Neither the read nor the write capture takes effect. A pending commit via `ready` still proceeds.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. `count` increments on push, decrements on pop, and is unchanged when both occur.
- Sticky flags clear only on `reset`.

## Timing
- All outputs are registered except `full` and `empty`.
- Reset values:
  - `rdata` = 0; `rvalid` = 0; `count` = 0.
  - All sticky flags = 0.
  - `stage_valid` = 0; both pointers = 0.
  - FIFO memory contents are not reset.
- Write path latency: `write` at cycle N, `ready` at N+1, entry visible in `count` at N+2. A commit in the same cycle as the write is impossible, because staging is registered.
- Read latency: `read` at N gives `rdata`/`rvalid` at N+1. `rvalid` is a single-cycle pulse per accepted read; back-to-back reads give back-to-back pulses.
- `reset` asserted mid-operation wins over all other inputs that cycle. Staged and queued data are discarded.
- Flags assert on the edge following the offending cycle and then hold.

## Test plan
- Write/commit/read: `write` with `wdata=0x5A` at cycle 1, `ready` at 2, `read` at 4 → `count=1` at 3, `rdata=0x5A` with `rvalid=1` at 5, `count=0`, no flags.
- Fill and overflow (DEPTH=4): commit 0x01..0x04 → `full=1`. Fifth write of 0x05 plus `ready` → `overflow=1`, `count` stays 4. Four reads return 0x01..0x04 in order, then `empty=1`.
- Wrap-around: push/pop 10 values 0x10..0x19, interleaved so pointers wrap twice → reads return them in order, and `count` never exceeds 2.
- Underflow and stray ready: `read` on empty FIFO → `rvalid=0`, `underflow=1`. `ready` with no staged write → `stray_ready=1`, `count` unchanged.
- Conflict and overlap:
  - `read && write` with `wdata=0xAA` → `rw_conflict=1`, nothing staged, no `rvalid`.
  - `write 0x11`, then `write 0x22` together with `ready` → 0x11 committed and 0x22 staged. A further `ready` commits 0x22, giving `count=2`.
- Reset mid-operation: with `count=3` and a staged write, assert `reset` for one cycle together with `ready` → next cycle `count=0`, `empty=1`, `rvalid=0`, all flags 0, and nothing committed.

Source files
------------

// File: rtl/rw_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rw_capture_fifo
// Description : Staged-write capture FIFO with registered pop response and
//               sticky protocol-violation flags.
// Revision    : 1.0 - initial release
// ============================================================================
module rw_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       read,
    input  logic                       write,
    input  logic                       ready,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rvalid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       stray_ready,
    output logic                       rw_conflict
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               stage_valid_q, stage_valid_d;
    logic [WIDTH-1:0]   stage_data_q,  stage_data_d;
    logic [c_PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic [c_CNT_W-1:0] count_q,       count_d;
    logic [WIDTH-1:0]   rdata_q,       rdata_d;
    logic               rvalid_q,      rvalid_d;
    logic               overflow_q,    overflow_d;
    logic               underflow_q,   underflow_d;
    logic               stray_ready_q, stray_ready_d;
    logic               rw_conflict_q, rw_conflict_d;

    logic               w_full;
    logic               w_empty;
    logic               w_conflict;
    logic               w_commit;
    logic               w_push;
    logic               w_pop;

    assign w_full  = (count_q == c_CNT_W'(DEPTH));
    assign w_empty = (count_q == '0);

    // A read/write collision cancels both captures but leaves a commit alone.
    assign w_conflict = read && write;
    assign w_commit   = ready && stage_valid_q;
    assign w_push     = w_commit && !w_full;
    assign w_pop      = read && !w_conflict && !w_empty;

    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_data_d  = stage_data_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        rdata_d       = rdata_q;
        rvalid_d      = 1'b0;
        overflow_d    = overflow_q;
        underflow_d   = underflow_q;
        stray_ready_d = stray_ready_q;
        rw_conflict_d = rw_conflict_q;

        // The old staged value commits before a same-cycle write reloads it.
        if (write && !w_conflict) begin
            stage_valid_d = 1'b1;
            stage_data_d  = wdata;
        end else if (w_commit) begin
            stage_valid_d = 1'b0;
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rdata_d  = mem_q[rd_ptr_q];
            rvalid_d = 1'b1;
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

        if (w_commit && w_full) begin
            overflow_d = 1'b1;
        end
        if (read && !w_conflict && w_empty) begin
            underflow_d = 1'b1;
        end
        if (ready && !stage_valid_q) begin
            stray_ready_d = 1'b1;
        end
        if (w_conflict) begin
            rw_conflict_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            stray_ready_q <= 1'b0;
            rw_conflict_q <= 1'b0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            stray_ready_q <= stray_ready_d;
            rw_conflict_q <= rw_conflict_d;
        end
    end

    // Storage is deliberately left out of reset; count and pointers gate it.
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            mem_q[wr_ptr_q] <= stage_data_q;
        end
    end

    assign rdata       = rdata_q;
    assign rvalid      = rvalid_q;
    assign count       = count_q;
    assign full        = w_full;
    assign empty       = w_empty;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign stray_ready = stray_ready_q;
    assign rw_conflict = rw_conflict_q;

endmodule
`default_nettype wire
